hls_deadlock_monitor_param: RTL and testbench
=============================================

Name: hls_deadlock_monitor_param

Overview:
- Parametrised dataflow deadlock monitor for one HLS dataflow region; successor to the fixed-size per-region monitors.
- Maps any number of AXI-stream block signals onto any number of processes.
- Requires a stall to persist a programmable number of cycles before flagging it, with optional sticky reporting.
- Captures a diagnostic snapshot of the blocked processes for the debug/status path.

Parameters:
- NUM_PROC, 9, number of dataflow processes monitored.
- NUM_AXIS, 1, number of AXI-stream block inputs.
- AXIS_OWNER, {NUM_AXIS{8'd0}}, packed NUM_AXIS*8-bit map. Byte a = index of the process owning axis channel a. Values >= NUM_PROC are ignored.
- STALL_CYCLES, 1, consecutive stalled cycles required before block asserts; range 1..65535.
- STICKY, 0, when 1, block holds until clear or reset.
- IDX_W, 8, width of blk_first_idx.

Ports:
- clock  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- axis_block_sigs  in  NUM_AXIS  per-channel AXIS blocked.
- inst_idle_sigs  in  NUM_PROC  per-process idle.
- inst_block_sigs  in  NUM_PROC  per-process FIFO/channel blocked.
- clear  in  1  synchronous clear of sticky state, snapshot and count.
- block  out  1  deadlock flag.
- block_event  out  1  one-cycle pulse on entry to BLOCKED.
- blk_proc_chan  out  NUM_PROC  snapshot of inst_block_sigs at entry.
- blk_proc_axis  out  NUM_PROC  snapshot of per-process AXIS block at entry.
- blk_first_idx  out  IDX_W  lowest process index with AXIS block at entry.
- block_count  out  16  saturating count of BLOCKED entries.

Behaviour:
- Combinational condition:
  - proc_axis[p] = OR over a of (axis_block_sigs[a] & AXIS_OWNER[a] == p).
  - stop[p] = inst_idle_sigs[p] | inst_block_sigs[p] | proc_axis[p].
  - cond = (|proc_axis) & (&stop).
- FSM states: RUN, SUSPECT, BLOCKED. There is a 16-bit run counter cnt.
- RUN:
  - cond=1 and STALL_CYCLES==1 -> BLOCKED.
  - cond=1 otherwise -> SUSPECT, cnt=1.
  - Else stay in RUN, cnt=0.
- SUSPECT:
  - cond=0 -> RUN, cnt=0.
  - cnt+1==STALL_CYCLES -> BLOCKED.
  - Else cnt++.
- BLOCKED:
  - STICKY=0 and cond=0 -> RUN, cnt=0.
  - STICKY=1: stay until clear.
- Latency: block rises at the clock edge that samples the STALL_CYCLES-th consecutive cycle with cond=1. With STALL_CYCLES=1, block is registered one cycle after cond, the same as the legacy monitor.
- Non-sticky deassertion: block falls at the first edge that samples cond=0.
- Registered output: block = (state==BLOCKED).
- block_event = 1 for exactly the edge that transitions into BLOCKED.
- On entry to BLOCKED, in the same edge as block_event:
  - Latch blk_proc_chan and blk_proc_axis from the current inputs.
  - blk_first_idx = lowest p with proc_axis[p]=1.
  - block_count increments, saturating at 16'hFFFF.
- Snapshots hold until the next entry, clear, or reset.
- Reset (priority 1): state=RUN, cnt=0. All outputs 0: block, block_event, blk_proc_chan, blk_proc_axis, blk_first_idx, block_count.
- clear (priority 2): same effect as reset on the FSM, outputs and count. clear wins over a simultaneous entry; no event, no count.
- Reset or clear mid-SUSPECT abandons the stall run; the qualification restarts from 0.
- Dropout: cond dropping for one cycle in SUSPECT resets qualification fully; there is no partial credit.

Test Plan:
- Defaults, AXIS blocked, all processes idle at cycle 10 -> block=1 and block_event=1 after edge 11. With cond held, block stays 1 and block_event is 0 from edge 12.
- STALL_CYCLES=4, cond high 3 cycles, low 1, high 4 -> block remains 0 for the first run. It asserts on the 4th edge of the second run; block_count=1.
- NUM_PROC=4, NUM_AXIS=3, AXIS_OWNER={8'd3,8'd1,8'd1}, axis[1] blocked, procs 0,2,3 idle, proc 1 chan-blocked -> block=1, blk_first_idx=1, blk_proc_axis=4'b0010, blk_proc_chan=4'b0010.
- AXIS blocked but one process neither idle nor blocked -> block stays 0 indefinitely. Also: all processes idle but no AXIS block -> block=0.
- STICKY=1: block asserts, then cond=0 -> block stays 1. clear pulse -> block=0, block_count=0 next edge. Clear asserted on the qualifying edge -> no block_event.
- Force block_count to 16'hFFFF via repeated non-sticky entries -> it stays 16'hFFFF. Reset mid-SUSPECT -> all outputs 0, requalification needs a full STALL_CYCLES.

Source files
------------

// File: rtl/hls_deadlock_monitor_param.sv
// ----------------------------------------------------------------------------
// hls_deadlock_monitor_param
//
// Deadlock monitor for a single HLS dataflow region. Any number of AXI-stream
// block signals can be mapped onto any number of dataflow processes. A
// deadlock is suspected when at least one process is stuck on an AXI-stream
// channel and every process is idle, FIFO-blocked or AXIS-blocked. The stall
// must persist for STALL_CYCLES consecutive cycles before it is reported.
// On entry to the blocked state the blocked-process pattern is captured for
// the debug/status path.
//
// Ports:
//   clock            sole clock, all logic on posedge
//   reset            synchronous, active-high
//   axis_block_sigs  [NUM_AXIS] per-channel AXI-stream blocked
//   inst_idle_sigs   [NUM_PROC] per-process idle
//   inst_block_sigs  [NUM_PROC] per-process FIFO/channel blocked
//   clear            synchronous clear of sticky state, snapshot and count
//   block            deadlock flag (registered)
//   block_event      one-cycle pulse on entry to the blocked state
//   blk_proc_chan    [NUM_PROC] inst_block_sigs captured at entry
//   blk_proc_axis    [NUM_PROC] per-process AXIS block captured at entry
//   blk_first_idx    [IDX_W] lowest process index with AXIS block at entry
//   block_count      [16] saturating count of entries into the blocked state
// ----------------------------------------------------------------------------
module hls_deadlock_monitor_param #(
  parameter int                     NUM_PROC     = 9,
  parameter int                     NUM_AXIS     = 1,
  parameter logic [NUM_AXIS*8-1:0]  AXIS_OWNER   = {NUM_AXIS{8'd0}},
  parameter int                     STALL_CYCLES = 1,
  parameter bit                     STICKY       = 1'b0,
  parameter int                     IDX_W        = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_PROC-1:0] inst_idle_sigs,
  input  logic [NUM_PROC-1:0] inst_block_sigs,
  input  logic                clear,
  output logic                block,
  output logic                block_event,
  output logic [NUM_PROC-1:0] blk_proc_chan,
  output logic [NUM_PROC-1:0] blk_proc_axis,
  output logic [IDX_W-1:0]    blk_first_idx,
  output logic [15:0]         block_count
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_BLOCKED = 2'd2
  } state_t;

  // Qualification finishes when the run counter has already seen
  // STALL_CYCLES-1 stalled cycles and the current cycle is stalled too.
  localparam logic [15:0] LAST_CNT = 16'(STALL_CYCLES - 1);
  localparam bit          SINGLE   = (STALL_CYCLES <= 1);

  // --------------------------------------------------------------------------
  // Per-process AXIS block: a process is AXIS-blocked when any channel it owns
  // is blocked. Ownership is resolved at elaboration time, so owner bytes that
  // name a non-existent process simply never match.
  // --------------------------------------------------------------------------
  logic [NUM_PROC-1:0] proc_axis;

  for (genvar gi = 0; gi < NUM_PROC; gi++) begin : g_proc
    logic [NUM_AXIS-1:0] hit;
    for (genvar ai = 0; ai < NUM_AXIS; ai++) begin : g_chan
      localparam bit OWNS = (int'(AXIS_OWNER[ai*8 +: 8]) == gi);
      assign hit[ai] = axis_block_sigs[ai] & OWNS;
    end
    assign proc_axis[gi] = |hit;
  end

  logic [NUM_PROC-1:0] stop;
  logic                cond;

  assign stop = inst_idle_sigs | inst_block_sigs | proc_axis;
  assign cond = (|proc_axis) & (&stop);

  // Lowest-index AXIS-blocked process; scanning downwards lets the lowest
  // match overwrite any higher one.
  logic [IDX_W-1:0] first_idx;

  always_comb begin
    first_idx = '0;
    for (int p = NUM_PROC - 1; p >= 0; p--) begin
      if (proc_axis[p]) begin
        first_idx = IDX_W'(p);
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        enter;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    enter      = 1'b0;
    case (state_reg)
      ST_RUN: begin
        cnt_next = 16'd0;
        if (cond) begin
          if (SINGLE) begin
            state_next = ST_BLOCKED;
            enter      = 1'b1;
          end else begin
            state_next = ST_SUSPECT;
            cnt_next   = 16'd1;
          end
        end
      end
      ST_SUSPECT: begin
        if (!cond) begin
          // any gap in the stall discards the whole run
          state_next = ST_RUN;
          cnt_next   = 16'd0;
        end else if (cnt_reg == LAST_CNT) begin
          state_next = ST_BLOCKED;
          cnt_next   = 16'd0;
          enter      = 1'b1;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      ST_BLOCKED: begin
        cnt_next = 16'd0;
        if (!STICKY && !cond) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_RUN;
        cnt_next   = 16'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State, pulse and snapshot registers. clear has the same effect as reset
  // and therefore also suppresses an entry that coincides with it.
  // --------------------------------------------------------------------------
  logic                block_event_reg;
  logic [NUM_PROC-1:0] blk_proc_chan_reg;
  logic [NUM_PROC-1:0] blk_proc_axis_reg;
  logic [IDX_W-1:0]    blk_first_idx_reg;
  logic [15:0]         block_count_reg;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state_reg         <= ST_RUN;
      cnt_reg           <= 16'd0;
      block_event_reg   <= 1'b0;
      blk_proc_chan_reg <= '0;
      blk_proc_axis_reg <= '0;
      blk_first_idx_reg <= '0;
      block_count_reg   <= 16'd0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      block_event_reg <= enter;
      if (enter) begin
        blk_proc_chan_reg <= inst_block_sigs;
        blk_proc_axis_reg <= proc_axis;
        blk_first_idx_reg <= first_idx;
        if (block_count_reg != 16'hFFFF) begin
          block_count_reg <= block_count_reg + 16'd1;
        end
      end
    end
  end

  assign block         = (state_reg == ST_BLOCKED);
  assign block_event   = block_event_reg;
  assign blk_proc_chan = blk_proc_chan_reg;
  assign blk_proc_axis = blk_proc_axis_reg;
  assign blk_first_idx = blk_first_idx_reg;
  assign block_count   = block_count_reg;

endmodule

// File: tb/tb_hls_deadlock_monitor_param.sv
// ----------------------------------------------------------------------------
// Testbench for hls_deadlock_monitor_param. Five differently parameterised
// instances run side by side; a behavioural model tracks, per instance, the
// length of the current run of stalled cycles and derives the expected flag,
// pulse, snapshots and count from it. Directed stimulus adds literal checks.
//   u0: defaults                          u1: NUM_PROC=3, STALL_CYCLES=4
//   u2: NUM_PROC=4, NUM_AXIS=3, owners {3,1,1}
//   u3: NUM_PROC=2, NUM_AXIS=2, STICKY=1, STALL_CYCLES=2
//   u4: NUM_PROC=2, count saturation
// ----------------------------------------------------------------------------
module tb_hls_deadlock_monitor_param;

  localparam int          N      = 5;
  localparam int          NP [N] = '{9, 3, 4, 2, 2};
  localparam int          NA [N] = '{1, 1, 3, 2, 1};
  localparam int          ST [N] = '{1, 4, 1, 2, 1};
  localparam bit          SK [N] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [23:0] OW [N] = '{24'h0, 24'h0, 24'h030101, 24'h000100, 24'h0};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [N-1:0] rst;
  logic [N-1:0] clr;
  logic [3:0]   axis_v [N];
  logic [15:0]  idle_v [N];
  logic [15:0]  iblk_v [N];

  wire  [N-1:0] blk_o;
  wire  [N-1:0] ev_o;
  wire  [15:0]  chan_o  [N];
  wire  [15:0]  paxis_o [N];
  wire  [15:0]  cnt_o   [N];
  wire  [7:0]   idx_o   [N];

  for (genvar gi = 0; gi < N; gi++) begin : gen_dut
    logic [NP[gi]-1:0] w_chan, w_axis;
    logic [7:0]        w_idx;
    logic [15:0]       w_cnt;
    logic              w_blk, w_ev;

    hls_deadlock_monitor_param #(
      .NUM_PROC    (NP[gi]),
      .NUM_AXIS    (NA[gi]),
      .AXIS_OWNER  (OW[gi][NA[gi]*8-1:0]),
      .STALL_CYCLES(ST[gi]),
      .STICKY      (SK[gi]),
      .IDX_W       (8)
    ) u_dut (
      .clock          (clock),
      .reset          (rst[gi]),
      .axis_block_sigs(axis_v[gi][NA[gi]-1:0]),
      .inst_idle_sigs (idle_v[gi][NP[gi]-1:0]),
      .inst_block_sigs(iblk_v[gi][NP[gi]-1:0]),
      .clear          (clr[gi]),
      .block          (w_blk),
      .block_event    (w_ev),
      .blk_proc_chan  (w_chan),
      .blk_proc_axis  (w_axis),
      .blk_first_idx  (w_idx),
      .block_count    (w_cnt)
    );

    assign blk_o[gi]   = w_blk;
    assign ev_o[gi]    = w_ev;
    assign chan_o[gi]  = 16'(w_chan);
    assign paxis_o[gi] = 16'(w_axis);
    assign cnt_o[gi]   = w_cnt;
    assign idx_o[gi]   = w_idx;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input int i, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s u%0d got %h expected %h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  int          m_run [N] = '{default: 0};
  bit          m_blk [N] = '{default: 1'b0};
  bit          m_ev  [N] = '{default: 1'b0};
  logic [15:0] m_chan[N] = '{default: 16'h0};
  logic [15:0] m_pax [N] = '{default: 16'h0};
  logic [15:0] m_cnt [N] = '{default: 16'h0};
  logic [7:0]  m_idx [N] = '{default: 8'h0};
  bit          preset = 1'b0;
  bit          cmp_en = 1'b0;

  function automatic logic [15:0] paxis_of(input int i);
    logic [15:0] r;
    r = '0;
    for (int a = 0; a < NA[i]; a++) begin
      if (axis_v[i][a]) begin
        int o;
        o = int'(OW[i][a*8 +: 8]);
        if (o < NP[i]) r[o] = 1'b1;
      end
    end
    return r;
  endfunction

  always @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      logic [15:0] pa, mask;
      bit          c, now;
      int          first;
      pa    = paxis_of(i);
      mask  = 16'((32'd1 << NP[i]) - 1);
      c     = (pa != 16'h0);
      first = -1;
      for (int p = 0; p < NP[i]; p++) begin
        if (!(idle_v[i][p] | iblk_v[i][p] | pa[p])) c = 1'b0;
        if (pa[p] && first < 0) first = p;
      end
      if (i == 4 && preset) m_cnt[i] = 16'hFFFE;
      if (rst[i] || clr[i]) begin
        m_run[i] = 0; m_blk[i] = 0; m_ev[i] = 0;
        m_chan[i] = 0; m_pax[i] = 0; m_idx[i] = 0; m_cnt[i] = 0;
      end else begin
        m_run[i] = c ? m_run[i] + 1 : 0;
        if (m_run[i] > 70000) m_run[i] = 70000;
        now      = (SK[i] && m_blk[i]) || (m_run[i] >= ST[i]);
        m_ev[i]  = now && !m_blk[i];
        if (m_ev[i]) begin
          m_chan[i] = iblk_v[i] & mask;
          m_pax[i]  = pa;
          m_idx[i]  = 8'(first);
          m_cnt[i]  = (m_cnt[i] == 16'hFFFF) ? 16'hFFFF : m_cnt[i] + 16'd1;
        end
        m_blk[i] = now;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      for (int i = 0; i < N; i++) begin
        check("block", i, 16'(blk_o[i]), 16'(m_blk[i]));
        check("block_event", i, 16'(ev_o[i]), 16'(m_ev[i]));
        check("blk_proc_chan", i, chan_o[i], m_chan[i]);
        check("blk_proc_axis", i, paxis_o[i], m_pax[i]);
        check("blk_first_idx", i, 16'(idx_o[i]), 16'(m_idx[i]));
        check("block_count", i, cnt_o[i], m_cnt[i]);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // --------------------------------------------------------------------------
  initial begin
    rst = '1;
    clr = '0;
    for (int i = 0; i < N; i++) begin
      axis_v[i] = '0; idle_v[i] = '0; iblk_v[i] = '0;
    end
    repeat (2) @(negedge clock);
    cmp_en = 1'b1;
    for (int i = 0; i < N; i++) begin
      check("lit_rst_block", i, 16'(blk_o[i]), 16'h0);
      check("lit_rst_count", i, cnt_o[i], 16'h0);
    end
    rst = '0;
    repeat (7) @(negedge clock);

    // u0: single-cycle qualification
    idle_v[0] = 16'h01FF; axis_v[0] = 4'h1;
    @(negedge clock);
    check("lit_u0_block", 0, 16'(blk_o[0]), 16'h1);
    check("lit_u0_event", 0, 16'(ev_o[0]), 16'h1);
    @(negedge clock);
    check("lit_u0_block_hold", 0, 16'(blk_o[0]), 16'h1);
    check("lit_u0_event_low", 0, 16'(ev_o[0]), 16'h0);
    check("lit_u0_count", 0, cnt_o[0], 16'h1);
    check("lit_u0_axis", 0, paxis_o[0], 16'h0001);
    axis_v[0] = 4'h0;
    @(negedge clock);
    check("lit_u0_fall", 0, 16'(blk_o[0]), 16'h0);
    idle_v[0] = 16'h00FF; axis_v[0] = 4'h1;   // process 8 still running
    repeat (20) @(negedge clock);
    check("lit_u0_busy", 0, 16'(blk_o[0]), 16'h0);
    axis_v[0] = 4'h0; idle_v[0] = 16'h01FF;   // all idle, no AXIS block
    repeat (5) @(negedge clock);
    check("lit_u0_idle", 0, 16'(blk_o[0]), 16'h0);
    idle_v[0] = 16'h0;

    // u1: STALL_CYCLES=4 with a dropout, then reset mid-run
    idle_v[1] = 16'h7; axis_v[1] = 4'h1;
    repeat (3) @(negedge clock);
    axis_v[1] = 4'h0;
    @(negedge clock);
    axis_v[1] = 4'h1;
    repeat (3) @(negedge clock);
    check("lit_u1_third", 1, 16'(blk_o[1]), 16'h0);
    @(negedge clock);
    check("lit_u1_fourth", 1, 16'(blk_o[1]), 16'h1);
    check("lit_u1_count", 1, cnt_o[1], 16'h1);
    axis_v[1] = 4'h0;
    @(negedge clock);
    axis_v[1] = 4'h1;
    repeat (2) @(negedge clock);
    rst[1] = 1'b1;
    @(negedge clock);
    rst[1] = 1'b0;
    check("lit_u1_rst_count", 1, cnt_o[1], 16'h0);
    repeat (3) @(negedge clock);
    check("lit_u1_requal3", 1, 16'(blk_o[1]), 16'h0);
    @(negedge clock);
    check("lit_u1_requal4", 1, 16'(blk_o[1]), 16'h1);
    axis_v[1] = 4'h0; idle_v[1] = 16'h0;
    @(negedge clock);

    // u2: channel-to-process mapping and snapshot
    axis_v[2] = 4'b0010; idle_v[2] = 16'b1101; iblk_v[2] = 16'b0010;
    @(negedge clock);
    check("lit_u2_block", 2, 16'(blk_o[2]), 16'h1);
    check("lit_u2_idx", 2, 16'(idx_o[2]), 16'h1);
    check("lit_u2_axis", 2, paxis_o[2], 16'b0010);
    check("lit_u2_chan", 2, chan_o[2], 16'b0010);
    axis_v[2] = 4'h0; idle_v[2] = 16'h0; iblk_v[2] = 16'h0;
    @(negedge clock);

    // u3: sticky, clear, clear on the qualifying edge
    axis_v[3] = 4'b0001; idle_v[3] = 16'b0010;
    @(negedge clock);
    check("lit_u3_first", 3, 16'(blk_o[3]), 16'h0);
    @(negedge clock);
    check("lit_u3_block", 3, 16'(blk_o[3]), 16'h1);
    axis_v[3] = 4'h0;
    repeat (5) @(negedge clock);
    check("lit_u3_sticky", 3, 16'(blk_o[3]), 16'h1);
    clr[3] = 1'b1;
    @(negedge clock);
    clr[3] = 1'b0;
    check("lit_u3_clr_block", 3, 16'(blk_o[3]), 16'h0);
    check("lit_u3_clr_count", 3, cnt_o[3], 16'h0);
    axis_v[3] = 4'b0001;
    @(negedge clock);
    clr[3] = 1'b1;
    @(negedge clock);
    clr[3] = 1'b0;
    check("lit_u3_clr_event", 3, 16'(ev_o[3]), 16'h0);
    check("lit_u3_clr_win", 3, 16'(blk_o[3]), 16'h0);
    @(negedge clock);
    @(negedge clock);
    check("lit_u3_requal", 3, 16'(blk_o[3]), 16'h1);
    axis_v[3] = 4'h0; idle_v[3] = 16'h0; clr[3] = 1'b1;
    @(negedge clock);
    clr[3] = 1'b0;

    // u4: count saturation
    idle_v[4] = 16'h3;
    repeat (3) begin
      axis_v[4] = 4'h1; @(negedge clock);
      axis_v[4] = 4'h0; @(negedge clock);
    end
    check("lit_u4_count3", 4, cnt_o[4], 16'h3);
    #2;
    force gen_dut[4].u_dut.block_count_reg = 16'hFFFE;
    preset = 1'b1;
    #1;
    release gen_dut[4].u_dut.block_count_reg;
    @(posedge clock);
    #1 preset = 1'b0;
    @(negedge clock);
    check("lit_u4_preset", 4, cnt_o[4], 16'hFFFE);
    repeat (3) begin
      axis_v[4] = 4'h1; @(negedge clock);
      check("lit_u4_sat", 4, cnt_o[4], 16'hFFFF);
      axis_v[4] = 4'h0; @(negedge clock);
    end
    check("lit_u4_sat_end", 4, cnt_o[4], 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
